// File: rtl/sinegen_pkg.sv
// Shared types and default widths for the sine-table address generator.
package sinegen_pkg;

   localparam int unsigned ACC_WIDTH_DEF     = 16;
   localparam int unsigned ADDRESS_WIDTH_DEF = 8;

   // Controller states: waiting for first config, running, config staged until next carry
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

endpackage

// File: rtl/sine_addr_gen.sv
// Phase-accumulator address generator feeding a dual-port sine table.
// Increment changes made while running are held back until the next
// accumulator carry so that a new frequency always starts on a period boundary.
module sine_addr_gen
   import sinegen_pkg::*;
#(
   parameter int unsigned ACC_WIDTH     = ACC_WIDTH_DEF,
   parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [ACC_WIDTH-1:0]     cfg_incr,
   input  logic [ADDRESS_WIDTH-1:0] cfg_offset,
   output logic [ADDRESS_WIDTH-1:0] addr1,
   output logic [ADDRESS_WIDTH-1:0] addr2,
   output logic                     addr_valid,
   output logic                     rom_valid,
   output logic                     wrap
);

   state_t                   state;
   logic [ACC_WIDTH-1:0]     acc;
   logic [ACC_WIDTH-1:0]     incr_act;
   logic [ACC_WIDTH-1:0]     incr_stg;
   logic [ADDRESS_WIDTH-1:0] offset_act;
   logic [ADDRESS_WIDTH-1:0] offset_stg;

   logic [ACC_WIDTH:0]       sum;
   logic                     carry;
   logic                     advance;
   logic                     cfg_xfer;

   // Accumulator sum with carry-out, and handshake/advance qualifiers
   always_comb begin
      sum      = {1'b0, acc} + {1'b0, incr_act};
      carry    = sum[ACC_WIDTH];
      advance  = en && (state != IDLE);
      cfg_xfer = cfg_valid && cfg_ready;
   end

   // Output decode straight from the state and accumulator registers
   always_comb begin
      cfg_ready  = (state != PEND);
      addr_valid = (state != IDLE);
      addr1      = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH];
      addr2      = addr1 + offset_act;
   end

   // Control FSM, accumulator and configuration registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         acc        <= '0;
         incr_act   <= '0;
         incr_stg   <= '0;
         offset_act <= '0;
         offset_stg <= '0;
         wrap       <= 1'b0;
      end else begin
         wrap <= advance && carry;
         if (advance) begin
            acc <= sum[ACC_WIDTH-1:0];
         end
         case (state)
            IDLE: begin
               if (cfg_xfer) begin
                  incr_act   <= cfg_incr;
                  offset_act <= cfg_offset;
                  state      <= RUN;
               end
            end
            RUN: begin
               if (cfg_xfer) begin
                  // A zero increment can never carry, so apply at once
                  if (incr_act == '0) begin
                     incr_act   <= cfg_incr;
                     offset_act <= cfg_offset;
                  end else begin
                     incr_stg   <= cfg_incr;
                     offset_stg <= cfg_offset;
                     state      <= PEND;
                  end
               end
            end
            PEND: begin
               // The carrying step itself still uses the old increment
               if (advance && carry) begin
                  incr_act   <= incr_stg;
                  offset_act <= offset_stg;
                  state      <= RUN;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Table read data lags the address by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_valid <= 1'b0;
      end else begin
         rom_valid <= addr_valid;
      end
   end

endmodule
